// File: rtl/polar_mem_pkg.sv
// Shared types and default constants for the polar decoder alpha (LLR) RAM front end.
package polar_mem_pkg;

  localparam int BITWIDTH_ADDRESS = 3;
  localparam int BITWIDTH_LLRS    = 7;
  localparam int DEPTH            = 6;
  localparam int NUM_LANES        = 128;
  localparam int CNT_W            = 8;

  typedef logic [NUM_LANES*BITWIDTH_LLRS-1:0] llr_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECODE = 2'd2
  } alpha_state_e;

endpackage

// File: rtl/alpha_mem_mux.sv
// Combinational RAM port mux: picks loader or core as the single RAM master and
// screens core addresses against the RAM depth.
module alpha_mem_mux
  import polar_mem_pkg::*;
#(
  parameter int BITWIDTH_ADDRESS = polar_mem_pkg::BITWIDTH_ADDRESS,
  parameter int BITWIDTH_LLRS    = polar_mem_pkg::BITWIDTH_LLRS,
  parameter int DEPTH            = polar_mem_pkg::DEPTH,
  parameter int NUM_LANES        = polar_mem_pkg::NUM_LANES
) (
  input  alpha_state_e                           i_state,
  input  logic                                   i_abort,
  input  logic                                   i_ld_valid,
  input  logic [NUM_LANES*BITWIDTH_LLRS-1:0]     i_ld_data,
  input  logic                                   i_core_req,
  input  logic                                   i_core_we,
  input  logic [BITWIDTH_ADDRESS-1:0]            i_core_addr,
  input  logic [NUM_LANES*BITWIDTH_LLRS-1:0]     i_core_wdata,
  input  logic [NUM_LANES*BITWIDTH_LLRS-1:0]     i_mem_rdata,
  output logic                                   o_ld_ready,
  output logic                                   o_core_gnt,
  output logic [NUM_LANES*BITWIDTH_LLRS-1:0]     o_core_rdata,
  output logic                                   o_illegal,
  output logic                                   o_mem_wr,
  output logic [BITWIDTH_ADDRESS-1:0]            o_mem_addr,
  output logic [NUM_LANES*BITWIDTH_LLRS-1:0]     o_mem_wdata
);

  // One extra bit so a DEPTH equal to 2**BITWIDTH_ADDRESS still compares correctly.
  localparam logic [BITWIDTH_ADDRESS:0] ADDR_LIMIT = (BITWIDTH_ADDRESS+1)'(DEPTH);

  logic w_legal;
  assign w_legal = {1'b0, i_core_addr} < ADDR_LIMIT;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    o_ld_ready  = 1'b0;
    o_core_gnt  = 1'b0;
    o_illegal   = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (i_state)
      LOAD: begin
        o_ld_ready  = 1'b1;
        o_mem_wr    = i_ld_valid;
        o_mem_wdata = i_ld_data;
      end
      DECODE: begin
        o_core_gnt  = i_core_req && w_legal && !i_abort;
        o_illegal   = i_core_req && !w_legal;
        o_mem_addr  = i_core_addr;
        o_mem_wr    = i_core_req && w_legal && !i_abort && i_core_we;
        o_mem_wdata = i_core_wdata;
      end
      default: ;
    endcase
  end

  assign o_core_rdata = (o_core_gnt && !i_core_we) ? i_mem_rdata : '0;

endmodule

// File: rtl/alpha_mem_arbiter.sv
// Frame sequencer (IDLE -> LOAD -> DECODE) for the alpha RAM, with sticky
// illegal-address flag and per-frame saturating access counter.
module alpha_mem_arbiter
  import polar_mem_pkg::*;
#(
  parameter int BITWIDTH_ADDRESS = polar_mem_pkg::BITWIDTH_ADDRESS,
  parameter int BITWIDTH_LLRS    = polar_mem_pkg::BITWIDTH_LLRS,
  parameter int DEPTH            = polar_mem_pkg::DEPTH,
  parameter int NUM_LANES        = polar_mem_pkg::NUM_LANES,
  parameter int CNT_W            = polar_mem_pkg::CNT_W
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                frame_start_i,
  input  logic                                abort_i,
  input  logic                                ld_valid_i,
  output logic                                ld_ready_o,
  input  logic [NUM_LANES*BITWIDTH_LLRS-1:0]  ld_data_i,
  input  logic                                core_req_i,
  input  logic                                core_we_i,
  input  logic [BITWIDTH_ADDRESS-1:0]         core_addr_i,
  input  logic [NUM_LANES*BITWIDTH_LLRS-1:0]  core_wdata_i,
  output logic                                core_gnt_o,
  output logic [NUM_LANES*BITWIDTH_LLRS-1:0]  core_rdata_o,
  input  logic                                frame_done_i,
  output logic                                mem_wr_o,
  output logic [BITWIDTH_ADDRESS-1:0]         mem_addr_o,
  output logic [NUM_LANES*BITWIDTH_LLRS-1:0]  mem_wdata_o,
  input  logic [NUM_LANES*BITWIDTH_LLRS-1:0]  mem_rdata_i,
  output logic                                busy_o,
  output logic                                decode_o,
  output logic                                err_o,
  output logic [CNT_W-1:0]                    acc_cnt_o
);

  alpha_state_e     r_state;
  alpha_state_e     w_next_state;
  logic             r_err;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             w_illegal;
  logic             w_load_entry;

  alpha_mem_mux #(
    .BITWIDTH_ADDRESS (BITWIDTH_ADDRESS),
    .BITWIDTH_LLRS    (BITWIDTH_LLRS),
    .DEPTH            (DEPTH),
    .NUM_LANES        (NUM_LANES)
  ) u_mux (
    .i_state      (r_state),
    .i_abort      (abort_i),
    .i_ld_valid   (ld_valid_i),
    .i_ld_data    (ld_data_i),
    .i_core_req   (core_req_i),
    .i_core_we    (core_we_i),
    .i_core_addr  (core_addr_i),
    .i_core_wdata (core_wdata_i),
    .i_mem_rdata  (mem_rdata_i),
    .o_ld_ready   (ld_ready_o),
    .o_core_gnt   (core_gnt_o),
    .o_core_rdata (core_rdata_o),
    .o_illegal    (w_illegal),
    .o_mem_wr     (mem_wr_o),
    .o_mem_addr   (mem_addr_o),
    .o_mem_wdata  (mem_wdata_o)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (abort_i) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (frame_start_i)            w_next_state = LOAD;
        LOAD:    if (ld_valid_i && ld_ready_o) w_next_state = DECODE;
        DECODE:  if (frame_done_i)             w_next_state = IDLE;
        default:                               w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o   = (r_state != IDLE);
    decode_o = (r_state == DECODE);
  end

  assign w_load_entry = (r_state == IDLE) && (w_next_state == LOAD);

  // Both statistics restart with each frame; the error flag is sticky within a frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err     <= 1'b0;
      r_acc_cnt <= '0;
    end else if (w_load_entry) begin
      r_err     <= 1'b0;
      r_acc_cnt <= '0;
    end else begin
      if (w_illegal) r_err <= 1'b1;
      if (core_gnt_o && (r_acc_cnt != {CNT_W{1'b1}})) r_acc_cnt <= r_acc_cnt + 1'b1;
    end
  end

  assign err_o     = r_err;
  assign acc_cnt_o = r_acc_cnt;

endmodule

// File: tb/tb_alpha_mem_arbiter.sv
// Self-checking bench for alpha_mem_arbiter: behavioural RAM, shadow memory and
// a read-data scoreboard.
module tb_alpha_mem_arbiter;
  import polar_mem_pkg::*;

  localparam int LW = NUM_LANES * BITWIDTH_LLRS;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic                        frame_start_i, abort_i, ld_valid_i, ld_ready_o;
  llr_vec_t                    ld_data_i;
  logic                        core_req_i, core_we_i, core_gnt_o;
  logic [BITWIDTH_ADDRESS-1:0] core_addr_i;
  llr_vec_t                    core_wdata_i, core_rdata_o;
  logic                        frame_done_i, mem_wr_o;
  logic [BITWIDTH_ADDRESS-1:0] mem_addr_o;
  llr_vec_t                    mem_wdata_o, mem_rdata_i;
  logic                        busy_o, decode_o, err_o;
  logic [CNT_W-1:0]            acc_cnt_o;

  llr_vec_t ram    [0:7];
  llr_vec_t shadow [0:DEPTH-1];
  llr_vec_t exp_q  [$];
  llr_vec_t exp_v;
  int n_checks = 0;
  int n_errors = 0;

  alpha_mem_arbiter dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .frame_start_i (frame_start_i), .abort_i (abort_i),
    .ld_valid_i (ld_valid_i), .ld_ready_o (ld_ready_o), .ld_data_i (ld_data_i),
    .core_req_i (core_req_i), .core_we_i (core_we_i), .core_addr_i (core_addr_i),
    .core_wdata_i (core_wdata_i), .core_gnt_o (core_gnt_o), .core_rdata_o (core_rdata_o),
    .frame_done_i (frame_done_i), .mem_wr_o (mem_wr_o), .mem_addr_o (mem_addr_o),
    .mem_wdata_o (mem_wdata_o), .mem_rdata_i (mem_rdata_i),
    .busy_o (busy_o), .decode_o (decode_o), .err_o (err_o), .acc_cnt_o (acc_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign mem_rdata_i = ram[mem_addr_o];
  always @(posedge clk_i) if (mem_wr_o) ram[mem_addr_o] <= mem_wdata_o;

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_inputs();
    frame_start_i = 0; abort_i = 0; ld_valid_i = 0; ld_data_i = '0;
    core_req_i = 0; core_we_i = 0; core_addr_i = '0; core_wdata_i = '0; frame_done_i = 0;
  endtask

  function automatic llr_vec_t make_vec(input logic [6:0] lane0, input int seed);
    llr_vec_t v;
    for (int i = 0; i < NUM_LANES; i++) v[i*BITWIDTH_LLRS +: BITWIDTH_LLRS] = 7'((i * seed + 3) & 7'h7f);
    v[6:0] = lane0;
    return v;
  endfunction

  // Stimulus only: IDLE -> LOAD -> DECODE with the given channel vector.
  task automatic start_frame(input llr_vec_t vec);
    frame_start_i = 1; step(); frame_start_i = 0;
    ld_valid_i = 1; ld_data_i = vec; shadow[0] = vec; step();
    ld_valid_i = 0; ld_data_i = '0;
  endtask

  task automatic test_reset();
    rst_ni = 0; clear_inputs();
    frame_start_i = 1; core_req_i = 1; ld_valid_i = 1; ld_data_i = '1;
    #2;
    n_checks++; if (busy_o !== 1'b0 || decode_o !== 1'b0) begin n_errors++; $display("FAIL reset_state: busy=%b decode=%b exp 0 0", busy_o, decode_o); end
    n_checks++; if (err_o !== 1'b0 || acc_cnt_o !== '0) begin n_errors++; $display("FAIL reset_stats: err=%b acc=%0d exp 0 0", err_o, acc_cnt_o); end
    n_checks++; if (ld_ready_o !== 1'b0 || core_gnt_o !== 1'b0 || core_rdata_o !== '0) begin n_errors++; $display("FAIL reset_ports: ld_ready=%b gnt=%b rdata!=0 exp all 0", ld_ready_o, core_gnt_o); end
    n_checks++; if (mem_wr_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin n_errors++; $display("FAIL reset_ram: wr=%b addr=%0d exp 0 0 and wdata 0", mem_wr_o, mem_addr_o); end
    clear_inputs();
    #6 rst_ni = 1;
    step();
  endtask

  task automatic test_load_read();
    llr_vec_t v;
    v = make_vec(7'h15, 5);
    frame_start_i = 1; step(); frame_start_i = 0; #1;
    n_checks++; if (busy_o !== 1'b1 || decode_o !== 1'b0 || ld_ready_o !== 1'b1) begin n_errors++; $display("FAIL load_state: busy=%b decode=%b ld_ready=%b exp 1 0 1", busy_o, decode_o, ld_ready_o); end
    ld_valid_i = 1; ld_data_i = v; core_req_i = 1; core_addr_i = 3'd1; #1;
    n_checks++; if (mem_wr_o !== 1'b1 || mem_addr_o !== 3'd0 || mem_wdata_o !== v) begin n_errors++; $display("FAIL load_write: wr=%b addr=%0d exp 1 0 (wdata match=%b)", mem_wr_o, mem_addr_o, mem_wdata_o === v); end
    n_checks++; if (core_gnt_o !== 1'b0) begin n_errors++; $display("FAIL load_no_gnt: gnt=%b exp 0", core_gnt_o); end
    shadow[0] = v;
    step(); clear_inputs(); #1;
    n_checks++; if (decode_o !== 1'b1 || ld_ready_o !== 1'b0) begin n_errors++; $display("FAIL decode_entry: decode=%b ld_ready=%b exp 1 0", decode_o, ld_ready_o); end
    core_req_i = 1; core_we_i = 0; core_addr_i = 3'd0; exp_q.push_back(shadow[0]); #1;
    n_checks++; if (core_gnt_o !== 1'b1) begin n_errors++; $display("FAIL read0_gnt: gnt=%b exp 1", core_gnt_o); end
    exp_v = exp_q.pop_front();
    n_checks++; if (core_rdata_o !== exp_v) begin n_errors++; $display("FAIL read0_data: lane0=%h exp %h", core_rdata_o[6:0], exp_v[6:0]); end
    n_checks++; if (core_rdata_o[6:0] !== 7'h15) begin n_errors++; $display("FAIL read0_lane0: got %h exp 15", core_rdata_o[6:0]); end
    step(); clear_inputs(); #1;
    n_checks++; if (acc_cnt_o !== 8'd1) begin n_errors++; $display("FAIL read0_cnt: acc=%0d exp 1", acc_cnt_o); end
  endtask

  task automatic test_write_read();
    llr_vec_t w;
    w = {NUM_LANES{7'h3C}};
    core_req_i = 1; core_we_i = 1; core_addr_i = 3'd5; core_wdata_i = w; #1;
    n_checks++; if (core_gnt_o !== 1'b1 || mem_wr_o !== 1'b1 || mem_addr_o !== 3'd5 || core_rdata_o !== '0) begin n_errors++; $display("FAIL wr5: gnt=%b wr=%b addr=%0d exp 1 1 5, rdata zero=%b", core_gnt_o, mem_wr_o, mem_addr_o, core_rdata_o === '0); end
    shadow[5] = w;
    step(); core_we_i = 0; core_wdata_i = '0; exp_q.push_back(shadow[5]); #1;
    n_checks++; if (acc_cnt_o !== 8'd2) begin n_errors++; $display("FAIL wr5_cnt: acc=%0d exp 2", acc_cnt_o); end
    n_checks++; if (core_gnt_o !== 1'b1) begin n_errors++; $display("FAIL rd5_gnt: gnt=%b exp 1", core_gnt_o); end
    exp_v = exp_q.pop_front();
    n_checks++; if (core_rdata_o !== exp_v) begin n_errors++; $display("FAIL rd5_data: lane0=%h lane127=%h exp 3c", core_rdata_o[6:0], core_rdata_o[LW-1 -: 7]); end
    step(); clear_inputs(); #1;
    n_checks++; if (acc_cnt_o !== 8'd3) begin n_errors++; $display("FAIL rd5_cnt: acc=%0d exp 3", acc_cnt_o); end
  endtask

  task automatic test_illegal();
    core_req_i = 1; core_we_i = 1; core_addr_i = 3'd6; core_wdata_i = '1; #1;
    n_checks++; if (core_gnt_o !== 1'b0 || mem_wr_o !== 1'b0 || core_rdata_o !== '0) begin n_errors++; $display("FAIL ill6: gnt=%b wr=%b exp 0 0", core_gnt_o, mem_wr_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errors++; $display("FAIL ill6_err_early: err=%b exp 0", err_o); end
    step(); core_we_i = 0; core_addr_i = 3'd7; #1;
    n_checks++; if (err_o !== 1'b1 || core_gnt_o !== 1'b0) begin n_errors++; $display("FAIL ill_err: err=%b gnt=%b exp 1 0", err_o, core_gnt_o); end
    step(); clear_inputs(); #1;
    n_checks++; if (acc_cnt_o !== 8'd3 || err_o !== 1'b1) begin n_errors++; $display("FAIL ill_hold: acc=%0d err=%b exp 3 1", acc_cnt_o, err_o); end
    frame_done_i = 1; step(); frame_done_i = 0; #1;
    n_checks++; if (busy_o !== 1'b0 || err_o !== 1'b1) begin n_errors++; $display("FAIL done_idle: busy=%b err=%b exp 0 1", busy_o, err_o); end
    frame_start_i = 1; step(); frame_start_i = 0; #1;
    n_checks++; if (err_o !== 1'b0 || acc_cnt_o !== '0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL reload_clear: err=%b acc=%0d busy=%b exp 0 0 1", err_o, acc_cnt_o, busy_o); end
  endtask

  task automatic test_blocking();
    llr_vec_t v;
    v = make_vec(7'h2A, 9);
    core_req_i = 1; core_we_i = 1; core_addr_i = 3'd3; core_wdata_i = '1; frame_start_i = 1; #1;
    n_checks++; if (core_gnt_o !== 1'b0 || mem_wr_o !== 1'b0 || mem_addr_o !== 3'd0) begin n_errors++; $display("FAIL load_block: gnt=%b wr=%b addr=%0d exp 0 0 0", core_gnt_o, mem_wr_o, mem_addr_o); end
    step(); frame_start_i = 0; frame_done_i = 1; step(); clear_inputs(); #1;
    n_checks++; if (busy_o !== 1'b1 || decode_o !== 1'b0) begin n_errors++; $display("FAIL load_ignore: busy=%b decode=%b exp 1 0", busy_o, decode_o); end
    ld_valid_i = 1; ld_data_i = v; shadow[0] = v; step(); #1;
    n_checks++; if (decode_o !== 1'b1 || ld_ready_o !== 1'b0 || mem_wr_o !== 1'b0) begin n_errors++; $display("FAIL decode_ld_block: decode=%b ld_ready=%b wr=%b exp 1 0 0", decode_o, ld_ready_o, mem_wr_o); end
    ld_valid_i = 0; frame_start_i = 1; step(); frame_start_i = 0; #1;
    n_checks++; if (decode_o !== 1'b1) begin n_errors++; $display("FAIL decode_ignore_start: decode=%b exp 1", decode_o); end
    core_req_i = 1; core_addr_i = 3'd0; exp_q.push_back(shadow[0]); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (core_gnt_o !== 1'b1 || core_rdata_o !== exp_v) begin n_errors++; $display("FAIL reload_read: gnt=%b lane0=%h exp 1 %h", core_gnt_o, core_rdata_o[6:0], exp_v[6:0]); end
    step(); clear_inputs();
  endtask

  task automatic test_abort_done();
    llr_vec_t p;
    p = make_vec(7'h5A, 11);
    core_req_i = 1; core_we_i = 1; core_addr_i = 3'd2; core_wdata_i = p; frame_done_i = 1; #1;
    n_checks++; if (core_gnt_o !== 1'b1 || mem_wr_o !== 1'b1 || mem_addr_o !== 3'd2) begin n_errors++; $display("FAIL done_write: gnt=%b wr=%b addr=%0d exp 1 1 2", core_gnt_o, mem_wr_o, mem_addr_o); end
    shadow[2] = p;
    step(); clear_inputs(); #1;
    n_checks++; if (busy_o !== 1'b0 || acc_cnt_o !== 8'd2) begin n_errors++; $display("FAIL done_idle2: busy=%b acc=%0d exp 0 2", busy_o, acc_cnt_o); end
    core_req_i = 1; core_we_i = 1; core_addr_i = 3'd4; #1;
    n_checks++; if (core_gnt_o !== 1'b0 || mem_wr_o !== 1'b0 || mem_addr_o !== 3'd0) begin n_errors++; $display("FAIL idle_block: gnt=%b wr=%b addr=%0d exp 0 0 0", core_gnt_o, mem_wr_o, mem_addr_o); end
    clear_inputs(); abort_i = 1; frame_start_i = 1; step(); clear_inputs(); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL abort_vs_start: busy=%b exp 0", busy_o); end
    frame_start_i = 1; step(); frame_start_i = 0; abort_i = 1; #1;
    n_checks++; if (mem_wr_o !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL abort_load: wr=%b busy=%b exp 0 1", mem_wr_o, busy_o); end
    step(); abort_i = 0; #1;
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL abort_load_idle: busy=%b exp 0", busy_o); end
    start_frame(make_vec(7'h01, 13));
    core_req_i = 1; core_addr_i = 3'd2; exp_q.push_back(shadow[2]); #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (core_gnt_o !== 1'b1 || core_rdata_o !== exp_v) begin n_errors++; $display("FAIL done_write_kept: gnt=%b lane0=%h exp 1 %h", core_gnt_o, core_rdata_o[6:0], exp_v[6:0]); end
    abort_i = 1; core_addr_i = 3'd0; #1;
    n_checks++; if (core_gnt_o !== 1'b0 || core_rdata_o !== '0) begin n_errors++; $display("FAIL abort_decode_gnt: gnt=%b exp 0", core_gnt_o); end
    step(); clear_inputs(); #1;
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL abort_decode_idle: busy=%b exp 0", busy_o); end
  endtask

  task automatic test_saturation();
    start_frame(make_vec(7'h33, 7));
    for (int i = 0; i < 300; i++) begin
      core_req_i = 1; core_we_i = 0; core_addr_i = 3'(i % DEPTH);
      exp_q.push_back(shadow[i % DEPTH]); #1;
      exp_v = exp_q.pop_front();
      n_checks++; if (core_gnt_o !== 1'b1 || core_rdata_o !== exp_v) begin n_errors++; $display("FAIL sat_read %0d: gnt=%b lane0=%h exp 1 %h", i, core_gnt_o, core_rdata_o[6:0], exp_v[6:0]); end
      step();
      if (i == 254) begin
        n_checks++; if (acc_cnt_o !== 8'd255) begin n_errors++; $display("FAIL sat_reach: acc=%0d exp 255", acc_cnt_o); end
      end
    end
    #1;
    n_checks++; if (acc_cnt_o !== 8'd255) begin n_errors++; $display("FAIL sat_hold: acc=%0d exp 255", acc_cnt_o); end
  endtask

  task automatic test_reset_mid();
    core_req_i = 1; core_we_i = 0; core_addr_i = 3'd5; ld_valid_i = 1; ld_data_i = '1; #1;
    n_checks++; if (decode_o !== 1'b1 || core_gnt_o !== 1'b1) begin n_errors++; $display("FAIL pre_reset: decode=%b gnt=%b exp 1 1", decode_o, core_gnt_o); end
    rst_ni = 0; #1;
    n_checks++; if (busy_o !== 1'b0 || decode_o !== 1'b0 || err_o !== 1'b0 || acc_cnt_o !== '0) begin n_errors++; $display("FAIL mid_reset_state: busy=%b decode=%b err=%b acc=%0d exp all 0", busy_o, decode_o, err_o, acc_cnt_o); end
    n_checks++; if (core_gnt_o !== 1'b0 || core_rdata_o !== '0 || ld_ready_o !== 1'b0) begin n_errors++; $display("FAIL mid_reset_ports: gnt=%b ld_ready=%b exp 0 0", core_gnt_o, ld_ready_o); end
    n_checks++; if (mem_wr_o !== 1'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin n_errors++; $display("FAIL mid_reset_ram: wr=%b addr=%0d exp 0 0", mem_wr_o, mem_addr_o); end
    clear_inputs(); step(); rst_ni = 1; step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    test_reset();
    test_load_read();
    test_write_read();
    test_illegal();
    test_blocking();
    test_abort_done();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alpha_mem_arbiter.md
Name: alpha_mem_arbiter

Overview:
- Front-end controller for the 6x128 alpha (LLR) RAM of the polar decoder.
- Sequences each frame: IDLE, then LOAD (channel LLR vector written to address 0), then DECODE (the SC core owns the RAM), then back to IDLE.
- Arbitrates the single RAM port between the channel loader and the decoder core.
- Rejects illegal addresses and reports per-frame access statistics.

Parameters:
- BITWIDTH_ADDRESS, 3, RAM address width.
- BITWIDTH_LLRS, 7, LLR width in bits.
- DEPTH, 6, number of RAM rows; legal addresses are 0..DEPTH-1.
- NUM_LANES, 128, LLRs per RAM row.
- CNT_W, 8, width of the access counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- frame_start_i  in  1  pulse; starts a new frame
- abort_i  in  1  pulse; abandons the current frame
- ld_valid_i  in  1  loader has a channel LLR vector
- ld_ready_o  out  1  loader vector accepted this cycle
- ld_data_i  in  NUM_LANES*BITWIDTH_LLRS  channel LLRs
- core_req_i  in  1  core access request
- core_we_i  in  1  1 = write, 0 = read
- core_addr_i  in  BITWIDTH_ADDRESS  core row address
- core_wdata_i  in  NUM_LANES*BITWIDTH_LLRS  core write data
- core_gnt_o  out  1  core access performed this cycle
- core_rdata_o  out  NUM_LANES*BITWIDTH_LLRS  read data
- frame_done_i  in  1  pulse; core finished the frame
- mem_wr_o  out  1  RAM write enable
- mem_addr_o  out  BITWIDTH_ADDRESS  RAM address
- mem_wdata_o  out  NUM_LANES*BITWIDTH_LLRS  RAM write data
- mem_rdata_i  in  NUM_LANES*BITWIDTH_LLRS  RAM read data (combinational from address)
- busy_o  out  1  state != IDLE
- decode_o  out  1  state == DECODE
- err_o  out  1  sticky illegal-address flag
- acc_cnt_o  out  CNT_W  granted core accesses in the current frame

Behaviour:
- Reset: state IDLE, err_o = 0, acc_cnt_o = 0. Every output is 0, including the RAM-side outputs.
- FSM transitions:
  - IDLE to LOAD on frame_start_i.
  - LOAD to DECODE on a cycle with ld_valid_i && ld_ready_o.
  - DECODE to IDLE on frame_done_i.
  - abort_i in any state goes to IDLE next cycle and has priority over every other event.
- Entering LOAD clears err_o and acc_cnt_o.
- LOAD:
  - ld_ready_o = 1 (combinational).
  - mem_wr_o = ld_valid_i, mem_addr_o = 0, mem_wdata_o = ld_data_i.
  - core_gnt_o = 0.
- DECODE:
  - core_gnt_o = core_req_i && (core_addr_i < DEPTH) && !abort_i.
  - mem_addr_o = core_addr_i.
  - mem_wr_o = core_gnt_o && core_we_i.
  - mem_wdata_o = core_wdata_i.
  - ld_ready_o = 0.
- Read latency 0: core_rdata_o = mem_rdata_i whenever core_gnt_o && !core_we_i, otherwise 0. Write data is visible to a read at the same address from the next cycle on.
- Illegal address (core_req_i in DECODE with core_addr_i >= DEPTH):
  - no grant, no write;
  - err_o set the next cycle and held until the next LOAD entry or reset.
- acc_cnt_o increments on each core_gnt_o and saturates at 2^CNT_W-1.
- Outside LOAD and DECODE, mem_wr_o = 0 and mem_addr_o = 0.
- Ignored events:
  - frame_start_i while not IDLE;
  - frame_done_i outside DECODE;
  - core_req_i outside DECODE (no grant);
  - ld_valid_i outside LOAD.
- Simultaneous frame_done_i and core_req_i in DECODE: the access is still granted, then the FSM goes to IDLE.
- frame_start_i in the same cycle as an abort_i from IDLE: abort wins, FSM stays IDLE.
- Reset during any state: immediate asynchronous return to reset values. The RAM contents are the RAM's own concern.
- State register: the only sequential elements are the state, err_o and acc_cnt_o. All RAM-side signals are combinational from the state and inputs.

Decomposition:
- Package polar_mem_pkg:
  - state enum alpha_state_e {IDLE, LOAD, DECODE};
  - llr_vec_t typedef (NUM_LANES x BITWIDTH_LLRS packed);
  - default constants DEPTH and BITWIDTH_ADDRESS.
- One natural sub-module: alpha_mem_mux. It is the purely combinational port mux and address check (grant, write enable, address, data select). The FSM and counters stay in the top module.

Test Plan:
- Load then read: reset, frame_start_i, ld_valid_i with lane0 = 7'h15 -> write at addr 0, decode_o = 1. Core read of addr 0 -> core_gnt_o = 1 same cycle, rdata lane0 = 7'h15, acc_cnt_o = 1.
- Write/read-back: in DECODE, write addr 5 with all lanes 7'h3C, then read addr 5 the next cycle -> 7'h3C on every lane, acc_cnt_o = 2.
- Illegal address: core_req_i with addr 6 -> core_gnt_o = 0, mem_wr_o = 0, err_o = 1 the next cycle. A following frame_start and load -> err_o = 0.
- Blocking: core_req_i during LOAD and IDLE -> no grant. ld_valid_i during DECODE -> ld_ready_o = 0, no RAM write.
- Abort and done: abort_i in LOAD -> IDLE next cycle, no write. frame_done_i together with a core write in DECODE -> write performed, then busy_o = 0.
- Saturation and reset: 300 granted reads -> acc_cnt_o = 255. Assert rst_ni low mid-DECODE -> all outputs 0 immediately.
